// File: rtl/mem_rd_scheduler.sv
// Read-miss scheduler in front of the cache-to-AXI bridge: round-robin icache/dcache grant,
// one outstanding read per source, and read-after-write blocking against unacked write-backs.
module mem_rd_scheduler #(
  parameter int LINE_OFF_W  = 4,
  parameter int WPEND_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_rd_req,
  input  logic        ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  input  logic        dc_rd_req,
  input  logic        dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  input  logic [2:0]  dc_rd_size,
  output logic        dc_rd_rdy,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_wr_addr,
  output logic        dc_wr_rdy,
  output logic        br_rd_req,
  output logic        br_rd_src,
  output logic        br_rd_type,
  output logic [31:0] br_rd_addr,
  output logic [2:0]  br_rd_size,
  input  logic        br_rd_rdy,
  input  logic        br_wr_rdy,
  input  logic        br_wr_ok,
  input  logic        br_inst_ret,
  input  logic        br_data_ret
);
  localparam int TAG_W = 32 - LINE_OFF_W;
  localparam int PTR_W = $clog2(WPEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state;
  logic   ic_busy, dc_busy, last_grant;

  logic [WPEND_DEPTH-1:0][TAG_W-1:0] wtag;
  logic [WPEND_DEPTH-1:0]            wvld;
  logic [PTR_W-1:0]                  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                  wcnt;

  logic full, push, pop, hit;
  logic ic_ok, dc_ok, grant_ic, grant_dc;
  logic unused_wr_off;

  assign unused_wr_off = ^dc_wr_addr[LINE_OFF_W-1:0];

  assign full      = (wcnt == CNT_W'(WPEND_DEPTH));
  assign dc_wr_rdy = br_wr_rdy & ~full;
  assign push      = dc_wr_req & dc_wr_rdy;
  assign pop       = br_wr_ok & (wcnt != '0);

  // Compare against tags registered before this cycle; a same-cycle push blocks from next cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WPEND_DEPTH; i++)
      if (wvld[i] && (wtag[i] == dc_rd_addr[31:LINE_OFF_W])) hit = 1'b1;
  end

  assign ic_ok = ic_rd_req & ~ic_busy;
  assign dc_ok = dc_rd_req & ~dc_busy & ~hit;

  // last_grant: 0=inst, 1=data; on a tie the other source wins.
  assign grant_ic = (state == IDLE) & ic_ok & (~dc_ok | last_grant);
  assign grant_dc = (state == IDLE) & dc_ok & (~ic_ok | ~last_grant);

  assign ic_rd_rdy = grant_ic;
  assign dc_rd_rdy = grant_dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      br_rd_req  <= 1'b0;
      br_rd_src  <= 1'b0;
      br_rd_type <= 1'b0;
      br_rd_addr <= '0;
      br_rd_size <= '0;
      ic_busy    <= 1'b0;
      dc_busy    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (br_inst_ret) ic_busy <= 1'b0;
      if (br_data_ret) dc_busy <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic || grant_dc) begin
            state      <= ISSUE;
            br_rd_req  <= 1'b1;
            br_rd_src  <= grant_dc;
            br_rd_type <= grant_dc ? dc_rd_type : ic_rd_type;
            br_rd_addr <= grant_dc ? dc_rd_addr : ic_rd_addr;
            br_rd_size <= grant_dc ? dc_rd_size : 3'd2;
            last_grant <= grant_dc;
            if (grant_ic) ic_busy <= 1'b1;
            if (grant_dc) dc_busy <= 1'b1;
          end
        end
        ISSUE: begin
          if (br_rd_rdy) begin
            state     <= IDLE;
            br_rd_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending write-back tags, oldest at rd_ptr; push and pop never hit the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wtag   <= '0;
      wvld   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wcnt   <= '0;
    end else begin
      if (pop) begin
        wvld[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wtag[wr_ptr] <= dc_wr_addr[31:LINE_OFF_W];
        wvld[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   wcnt <= wcnt + CNT_W'(1);
        2'b01:   wcnt <= wcnt - CNT_W'(1);
        default: wcnt <= wcnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rd_scheduler.sv
// Scenario bench for mem_rd_scheduler: grant expectations checked per cycle, issued read
// payloads scoreboarded against what the bench drove.
module tb_mem_rd_scheduler;
  typedef struct packed {
    logic        src;
    logic        typ;
    logic [31:0] addr;
    logic [2:0]  size;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_rd_req, ic_rd_type, ic_rd_rdy;
  logic [31:0] ic_rd_addr;
  logic        dc_rd_req, dc_rd_type, dc_rd_rdy;
  logic [31:0] dc_rd_addr;
  logic [2:0]  dc_rd_size;
  logic        dc_wr_req, dc_wr_rdy;
  logic [31:0] dc_wr_addr;
  logic        br_rd_req, br_rd_src, br_rd_type;
  logic [31:0] br_rd_addr;
  logic [2:0]  br_rd_size;
  logic        br_rd_rdy, br_wr_rdy, br_wr_ok, br_inst_ret, br_data_ret;

  int  n_chk = 0;
  int  n_pass = 0;
  rd_t exp_q[$];
  rd_t mon_exp;

  mem_rd_scheduler #(.LINE_OFF_W(4), .WPEND_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_size(dc_rd_size), .dc_rd_rdy(dc_rd_rdy),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_rdy(dc_wr_rdy),
    .br_rd_req(br_rd_req), .br_rd_src(br_rd_src), .br_rd_type(br_rd_type),
    .br_rd_addr(br_rd_addr), .br_rd_size(br_rd_size), .br_rd_rdy(br_rd_rdy),
    .br_wr_rdy(br_wr_rdy), .br_wr_ok(br_wr_ok),
    .br_inst_ret(br_inst_ret), .br_data_ret(br_data_ret)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  // Bridge-side scoreboard: every accepted read must match the oldest expected payload.
  always @(negedge clk) begin
    if (!reset && br_rd_req && br_rd_rdy) begin
      n_chk++;
      if (exp_q.size() == 0)
        $display("FAIL sb_unexpected: got %h want none", {br_rd_src, br_rd_type, br_rd_addr, br_rd_size});
      else begin
        mon_exp = exp_q.pop_front();
        if ({br_rd_src, br_rd_type, br_rd_addr, br_rd_size} !== mon_exp)
          $display("FAIL sb_payload: got %h want %h",
                   {br_rd_src, br_rd_type, br_rd_addr, br_rd_size}, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; br_wr_rdy = 1'b1; br_rd_rdy = 1'b1;
    repeat (2) step;
    settle;
    n_chk++; if ({br_rd_req, br_rd_src, br_rd_type, br_rd_addr, br_rd_size} !== '0)
      $display("FAIL rst_outputs: got %h want 0", {br_rd_req, br_rd_src, br_rd_type, br_rd_addr, br_rd_size});
    else n_pass++;
    step; reset = 1'b0;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL rst_wr_rdy: got %b want 1", dc_wr_rdy); else n_pass++;
    step; br_wr_rdy = 1'b0;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b0) $display("FAIL wr_rdy_gate: got %b want 0", dc_wr_rdy); else n_pass++;
    step; br_wr_rdy = 1'b1;
  endtask

  task automatic test_tie;
    step;
    ic_rd_req = 1'b1; ic_rd_type = 1'b1; ic_rd_addr = 32'h0000_1044;
    dc_rd_req = 1'b1; dc_rd_type = 1'b0; dc_rd_addr = 32'h2000_0048; dc_rd_size = 3'd2;
    settle;
    n_chk++; if ({ic_rd_rdy, dc_rd_rdy} !== 2'b10)
      $display("FAIL tie_first: got %b want 10", {ic_rd_rdy, dc_rd_rdy}); else n_pass++;
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_1044, 3'd2});
    step; ic_rd_req = 1'b0;
    settle;
    n_chk++; if ({br_rd_req, dc_rd_rdy} !== 2'b10)
      $display("FAIL tie_issue: got %b want 10", {br_rd_req, dc_rd_rdy}); else n_pass++;
    step;
    settle;
    n_chk++; if (dc_rd_rdy !== 1'b1) $display("FAIL tie_second: got %b want 1", dc_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b1, 1'b0, 32'h2000_0048, 3'd2});
    step; dc_rd_req = 1'b0;
    step; br_inst_ret = 1'b1; br_data_ret = 1'b1;
    step; br_inst_ret = 1'b0; br_data_ret = 1'b0;
  endtask

  task automatic test_alternate;
    logic nxt;
    logic [1:0] exp_g;
    nxt = 1'b0;
    for (int g = 0; g < 8; g++) begin
      step;
      if (g == 0) begin
        ic_rd_req = 1'b1; ic_rd_type = 1'b0; dc_rd_req = 1'b1; dc_rd_type = 1'b1; dc_rd_size = 3'd4;
        br_inst_ret = 1'b1; br_data_ret = 1'b1;
      end
      if (g % 2 == 0) begin
        ic_rd_addr = 32'h4000_0000 + 32'(g * 64);
        dc_rd_addr = 32'h5000_0000 + 32'(g * 64);
      end
      settle;
      exp_g = (g % 2 != 0) ? 2'b00 : (nxt ? 2'b01 : 2'b10);
      n_chk++; if ({ic_rd_rdy, dc_rd_rdy} !== exp_g)
        $display("FAIL alt_grant[%0d]: got %b want %b", g, {ic_rd_rdy, dc_rd_rdy}, exp_g);
      else n_pass++;
      if (g % 2 == 0) begin
        if (nxt) exp_q.push_back('{1'b1, 1'b1, dc_rd_addr, 3'd4});
        else     exp_q.push_back('{1'b0, 1'b0, ic_rd_addr, 3'd2});
        nxt = ~nxt;
      end
    end
    step; ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    step;
    step; br_inst_ret = 1'b0; br_data_ret = 1'b0;
  endtask

  task automatic test_raw;
    step; dc_wr_req = 1'b1; dc_wr_addr = 32'h1000_0010;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL raw_wr_rdy: got %b want 1", dc_wr_rdy); else n_pass++;
    step; dc_wr_req = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1000_001C; dc_rd_type = 1'b1; dc_rd_size = 3'd4;
    for (int k = 0; k < 3; k++) begin
      settle;
      n_chk++; if (dc_rd_rdy !== 1'b0) $display("FAIL raw_blocked[%0d]: got %b want 0", k, dc_rd_rdy); else n_pass++;
      step;
    end
    br_wr_ok = 1'b1;
    settle;
    n_chk++; if (dc_rd_rdy !== 1'b0) $display("FAIL raw_pop_cycle: got %b want 0", dc_rd_rdy); else n_pass++;
    step; br_wr_ok = 1'b0;
    settle;
    n_chk++; if (dc_rd_rdy !== 1'b1) $display("FAIL raw_after_pop: got %b want 1", dc_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b1, 1'b1, 32'h1000_001C, 3'd4});
    step; dc_rd_req = 1'b0;
    step; br_data_ret = 1'b1;
    step; br_data_ret = 1'b0;
  endtask

  task automatic test_wr_full;
    step; dc_wr_req = 1'b1; dc_wr_addr = 32'h2000_0000;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL full_wa: got %b want 1", dc_wr_rdy); else n_pass++;
    step; dc_wr_addr = 32'h2000_0010;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL full_wb: got %b want 1", dc_wr_rdy); else n_pass++;
    step; dc_wr_addr = 32'h2000_0020;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b0) $display("FAIL full_gate: got %b want 0", dc_wr_rdy); else n_pass++;
    step; br_wr_ok = 1'b1;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b0) $display("FAIL full_pop_cycle: got %b want 0", dc_wr_rdy); else n_pass++;
    step;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL full_pushpop: got %b want 1", dc_wr_rdy); else n_pass++;
    step; dc_wr_req = 1'b0; br_wr_ok = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h2000_0024; dc_rd_type = 1'b0; dc_rd_size = 3'd2;
    settle;
    n_chk++; if ({dc_wr_rdy, dc_rd_rdy} !== 2'b10)
      $display("FAIL full_hit_c: got %b want 10", {dc_wr_rdy, dc_rd_rdy}); else n_pass++;
    step; dc_rd_addr = 32'h2000_0018;
    settle;
    n_chk++; if (dc_rd_rdy !== 1'b1) $display("FAIL full_b_popped: got %b want 1", dc_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b1, 1'b0, 32'h2000_0018, 3'd2});
    step; dc_rd_req = 1'b0;
    step; br_data_ret = 1'b1;
    step; br_data_ret = 1'b0; br_wr_ok = 1'b1;
    step;
    step; br_wr_ok = 1'b0; dc_wr_req = 1'b1; dc_wr_addr = 32'h2000_0030;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b1) $display("FAIL empty_pop_wd: got %b want 1", dc_wr_rdy); else n_pass++;
    step; dc_wr_addr = 32'h2000_0040;
    step; dc_wr_req = 1'b0;
    settle;
    n_chk++; if (dc_wr_rdy !== 1'b0) $display("FAIL empty_pop_full: got %b want 0", dc_wr_rdy); else n_pass++;
    step; br_wr_ok = 1'b1;
    step;
    step; br_wr_ok = 1'b0;
  endtask

  task automatic test_busy;
    step; ic_rd_req = 1'b1; ic_rd_type = 1'b1; ic_rd_addr = 32'h0000_2000;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b1) $display("FAIL busy_first: got %b want 1", ic_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_2000, 3'd2});
    step; ic_rd_addr = 32'h0000_2100;
    step; dc_rd_req = 1'b1; dc_rd_type = 1'b0; dc_rd_addr = 32'h6000_0008; dc_rd_size = 3'd2;
    settle;
    n_chk++; if ({ic_rd_rdy, dc_rd_rdy} !== 2'b01)
      $display("FAIL busy_dc_grant: got %b want 01", {ic_rd_rdy, dc_rd_rdy}); else n_pass++;
    exp_q.push_back('{1'b1, 1'b0, 32'h6000_0008, 3'd2});
    step; dc_rd_req = 1'b0;
    step; br_data_ret = 1'b1;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b0) $display("FAIL busy_held: got %b want 0", ic_rd_rdy); else n_pass++;
    step; br_data_ret = 1'b0; br_inst_ret = 1'b1;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b0) $display("FAIL busy_ret_cycle: got %b want 0", ic_rd_rdy); else n_pass++;
    step; br_inst_ret = 1'b0;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b1) $display("FAIL busy_cleared: got %b want 1", ic_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b0, 1'b1, 32'h0000_2100, 3'd2});
    step; ic_rd_req = 1'b0;
    step; br_inst_ret = 1'b1;
    step; br_inst_ret = 1'b0;
  endtask

  task automatic test_reset_mid;
    step; br_rd_rdy = 1'b0; ic_rd_req = 1'b1; ic_rd_type = 1'b0; ic_rd_addr = 32'h0000_3000;
    dc_wr_req = 1'b1; dc_wr_addr = 32'h3000_0000;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b1) $display("FAIL mid_grant: got %b want 1", ic_rd_rdy); else n_pass++;
    step; ic_rd_req = 1'b0; dc_wr_req = 1'b0;
    step; reset = 1'b1;
    settle;
    n_chk++; if (br_rd_req !== 1'b1) $display("FAIL mid_stall: got %b want 1", br_rd_req); else n_pass++;
    step; reset = 1'b0;
    settle;
    n_chk++; if ({br_rd_req, br_rd_addr} !== 33'h0)
      $display("FAIL mid_flushed: got %h want 0", {br_rd_req, br_rd_addr}); else n_pass++;
    step; br_rd_rdy = 1'b1;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h3000_0004; dc_rd_type = 1'b0; dc_rd_size = 3'd1;
    settle;
    n_chk++; if (dc_rd_rdy !== 1'b1) $display("FAIL mid_table_empty: got %b want 1", dc_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b1, 1'b0, 32'h3000_0004, 3'd1});
    step; dc_rd_req = 1'b0; ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_3040;
    step;
    settle;
    n_chk++; if (ic_rd_rdy !== 1'b1) $display("FAIL mid_ic_free: got %b want 1", ic_rd_rdy); else n_pass++;
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_3040, 3'd2});
    step; ic_rd_req = 1'b0;
    step; br_inst_ret = 1'b1; br_data_ret = 1'b1;
    step; br_inst_ret = 1'b0; br_data_ret = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ic_rd_req = 1'b0; ic_rd_type = 1'b0; ic_rd_addr = '0;
    dc_rd_req = 1'b0; dc_rd_type = 1'b0; dc_rd_addr = '0; dc_rd_size = '0;
    dc_wr_req = 1'b0; dc_wr_addr = '0;
    br_rd_rdy = 1'b1; br_wr_rdy = 1'b1; br_wr_ok = 1'b0; br_inst_ret = 1'b0; br_data_ret = 1'b0;
    test_reset;
    test_tie;
    test_alternate;
    test_raw;
    test_wr_full;
    test_busy;
    test_reset_mid;
    repeat (3) step;
    n_chk++; if (exp_q.size() != 0)
      $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
